// File: rtl/shift_add_mult_sched_if.sv
// Handshake bundle for shift_add_mult_sched: two operand request ports and one result port.
// The design side uses the slave modport; the requester/consumer side uses master.
interface shift_add_mult_sched_if #(
  parameter int M = 8,
  parameter int N = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [M-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [M-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic           res_valid;
  logic           res_ready;
  logic           res_id;
  logic [M+N-1:0] res_p;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_p
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_p
  );
endinterface

// File: rtl/shift_add_mult_sched.sv
// Round-robin two-requester scheduler in front of an iterative shift-and-add multiplier.
// Optional build macro MULT_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | arbitrate requesters, accept one operand pair
// RUN   | one add-and-shift step per clock
// DONE  | product held on the result port until res_ready
module shift_add_mult_sched #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult_sched_if.slave bus
);
  localparam int W  = M + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   acc;
  logic [W-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   b_next;
  logic [CW-1:0]  cnt;
  logic           id;
  logic           rr;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           last_step;

  // rr only matters when both are valid; a lone requester is always granted.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  rr);

  assign bus.req0_ready = (state == IDLE) & rst & grant0;
  assign bus.req1_ready = (state == IDLE) & rst & grant1;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign b_next = b_sh >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign last_step = (cnt == CNT_LAST) || (b_next == '0);
`else
  assign last_step = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      id   <= 1'b0;
      rr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            cnt <= '0;
            if (bus.req0_ready) begin
              a_sh <= W'(bus.req0_a);
              b_sh <= bus.req0_b;
              id   <= 1'b0;
              rr   <= 1'b1;
            end else begin
              a_sh <= W'(bus.req1_a);
              b_sh <= bus.req1_b;
              id   <= 1'b1;
              rr   <= 1'b0;
            end
          end
        end
        RUN: begin
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_next;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result fields read zero outside DONE so stale products never leak.
  assign bus.res_valid = (state == DONE);
  assign bus.res_p     = (state == DONE) ? acc : '0;
  assign bus.res_id    = (state == DONE) & id;
endmodule

// File: tb/tb_shift_add_mult_sched.sv
// Self-checking bench for shift_add_mult_sched: vector table plus scoreboard queue,
// with hand-written sequences for arbitration, backpressure and reset mid-RUN.
module tb_shift_add_mult_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_pop = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mult_sched_if #(.M(8), .N(8)) bus ();

  shift_add_mult_sched #(.M(8), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          who;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] p;
    int          lat;
    int          acc_cyc;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];
  logic [7:0] da0[2], db0[2], da1[2], db1[2];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int exp_lat(input logic [7:0] b);
    int l;
    l = 8;
`ifdef MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  function automatic exp_t mk(input logic id, input logic [15:0] p, input int lat);
    exp_t e;
    e.id = id; e.p = p; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Result monitor: latency on rising res_valid, product/id on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (!bus.res_valid) begin
        chk("idle_p", bus.res_p, 0);
        chk("idle_id", bus.res_id, 0);
      end
      if (bus.res_valid && !prev_v) begin
        if (sbq.size() == 0) fail_now("unexpected_result");
        else if (sbq[0].lat >= 0) chk("latency", cyc - sbq[0].acc_cyc, sbq[0].lat);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sbq.size() == 0) begin
          fail_now("spurious_handshake");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_id", bus.res_id, e.id);
          chk("res_p", bus.res_p, e.p);
          n_pop++;
        end
      end
      prev_v = bus.res_valid;
    end
  end

  task automatic send(input bit who, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input int lat);
    bit   got;
    exp_t e;
    got = 1'b0;
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = who ? bus.req1_ready : bus.req0_ready;
      @(posedge clk); #1;
    end
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
    if (!got) begin
      fail_now("accept_timeout");
    end else begin
      e = mk(who, p, lat);
      e.acc_cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sbq.size() == 0);
    end
    if (!done) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Both requesters held valid; each reloads its next operands after an accept.
  task automatic dual(input int jobs);
    int k0, k1, base;
    bit a0, a1;
    k0 = 0; k1 = 0; base = n_pop;
    bus.req0_valid = 1'b1; bus.req0_a = da0[0]; bus.req0_b = db0[0];
    bus.req1_valid = 1'b1; bus.req1_a = da1[0]; bus.req1_b = db1[0];
    for (int i = 0; i < 400 && (k0 < jobs || k1 < jobs); i++) begin
      @(negedge clk);
      if (n_pop == base) chk("r1_wait", bus.req1_ready, 0);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      @(posedge clk); #1;
      if (a0) begin
        k0++;
        if (k0 < jobs) begin bus.req0_a = da0[k0]; bus.req0_b = db0[k0]; end
        else bus.req0_valid = 1'b0;
      end
      if (a1) begin
        k1++;
        if (k1 < jobs) begin bus.req1_a = da1[k1]; bus.req1_b = db1[k1]; end
        else bus.req1_valid = 1'b0;
      end
    end
    if (k0 < jobs || k1 < jobs) fail_now("dual_timeout");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'd143};
    vecs[1]  = '{1'b1, 8'd255, 8'd255, 16'd65025};
    vecs[2]  = '{1'b0, 8'd0,   8'd77,  16'd0};
    vecs[3]  = '{1'b1, 8'd1,   8'd1,   16'd1};
    vecs[4]  = '{1'b0, 8'd128, 8'd2,   16'd256};
    vecs[5]  = '{1'b1, 8'd200, 8'd100, 16'd20000};
    vecs[6]  = '{1'b0, 8'd255, 8'd1,   16'd255};
    vecs[7]  = '{1'b1, 8'd1,   8'd255, 16'd255};
    vecs[8]  = '{1'b0, 8'd77,  8'd1,   16'd77};
    vecs[9]  = '{1'b1, 8'd3,   8'd128, 16'd384};
    vecs[10] = '{1'b0, 8'd99,  8'd0,   16'd0};

    bus.req0_valid = 1'b1; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
    bus.res_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r0", bus.req0_ready, 0);
    chk("rst_r1", bus.req1_ready, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_p", bus.res_p, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests right after reset: requester 0 first.
    da0[0] = 8'd3; db0[0] = 8'd5; da1[0] = 8'd7; db1[0] = 8'd9;
    sbq.push_back(mk(1'b0, 16'd15, -1));
    sbq.push_back(mk(1'b1, 16'd63, -1));
    dual(1);
    wait_empty();

    // Back-to-back with both continuously valid: 0,1,0,1.
    da0[0] = 8'd10; db0[0] = 8'd3; da0[1] = 8'd20; db0[1] = 8'd4;
    da1[0] = 8'd11; db1[0] = 8'd5; da1[1] = 8'd12; db1[1] = 8'd6;
    sbq.push_back(mk(1'b0, 16'd30, -1));
    sbq.push_back(mk(1'b1, 16'd55, -1));
    sbq.push_back(mk(1'b0, 16'd80, -1));
    sbq.push_back(mk(1'b1, 16'd72, -1));
    dual(2);
    wait_empty();

    for (int v = 0; v < 11; v++) begin
      send(vecs[v].who, vecs[v].a, vecs[v].b, vecs[v].p, exp_lat(vecs[v].b));
      wait_empty();
    end

    // Backpressure: result held 20 cycles while both requesters wait.
    bus.res_ready = 1'b0;
    send(1'b0, 8'd13, 8'd11, 16'd143, exp_lat(8'd11));
    bus.req1_valid = 1'b1; bus.req1_a = 8'd6; bus.req1_b = 8'd7;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = bus.res_valid;
      end
      if (!seen) fail_now("bp_valid_timeout");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_p", bus.res_p, 143);
      chk("bp_id", bus.res_id, 0);
      chk("bp_r0", bus.req0_ready, 0);
      chk("bp_r1", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_ready", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    begin
      exp_t e;
      e = mk(1'b1, 16'd42, exp_lat(8'd7));
      e.acc_cyc = cyc;
      sbq.push_back(e);
    end
    wait_empty();

    // Reset at the 4th RUN edge drops the in-flight product.
    send(1'b0, 8'd200, 8'd100, 16'd20000, -1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    sbq.delete();
    chk("mid_valid", bus.res_valid, 0);
    chk("mid_p", bus.res_p, 0);
    chk("mid_id", bus.res_id, 0);
    chk("mid_r0", bus.req0_ready, 0);
    chk("mid_r1", bus.req1_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale", bus.res_valid, 0);
    end
    @(posedge clk); #1;
    da0[0] = 8'd2; db0[0] = 8'd2; da1[0] = 8'd5; db1[0] = 8'd5;
    sbq.push_back(mk(1'b0, 16'd4, -1));
    sbq.push_back(mk(1'b1, 16'd25, -1));
    dual(1);
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
